mp_subtractor: RTL and testbench



---
 rtl/mp_arith_pkg.sv | 19 +
 rtl/mp_limb_sub.sv | 22 ++
 rtl/mp_subtractor.sv | 111 +++++++++++
 tb/tb_mp_subtractor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mp_arith_pkg.sv
// Shared definitions for the multi-precision add/subtract datapath:
// FSM encoding, default operand geometry and counter sizing.
package mp_arith_pkg;

    localparam int unsigned DEF_WIDTH = 128;
    localparam int unsigned DEF_LIMB  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Limb counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_limb_sub.sv
// Combinational single-limb subtractor with borrow in/out:
// {bout, d} = a - b - bin evaluated at LIMB+1 bits.
module mp_limb_sub
    import mp_arith_pkg::*;
#(
    parameter int unsigned LIMB = DEF_LIMB
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            bin,
    output logic [LIMB-1:0] d,
    output logic            bout
);

    logic [LIMB:0] w_diff;

    // The extra top bit of the widened difference is the borrow out.
    assign w_diff = {1'b0, a} - {1'b0, b} - (LIMB+1)'(bin);
    assign d      = w_diff[LIMB-1:0];
    assign bout   = w_diff[LIMB];

endmodule

// File: rtl/mp_subtractor.sv
// Iterative multi-precision subtractor: C = {A<B, (A-B) mod 2^WIDTH},
// one limb per cycle, least-significant limb first.
module mp_subtractor
    import mp_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LIMB  = DEF_LIMB
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   C,
    output logic             done,
    output logic             busy
);

    localparam int unsigned      NUM_LIMBS = WIDTH / LIMB;
    localparam int unsigned      CNT_W     = cnt_width(NUM_LIMBS);
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_borrow;
    logic              r_done;
    logic              r_busy;
    logic [LIMB-1:0]   w_d;
    logic              w_bout;
    logic              w_done_nxt;
    logic              w_busy_nxt;

    mp_limb_sub #(
        .LIMB (LIMB)
    ) u_limb_sub (
        .a    (r_a[LIMB-1:0]),
        .b    (r_b[LIMB-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)              w_state_nxt = ST_SUB;
            ST_SUB:  if (r_cnt == LAST_LIMB) w_state_nxt = ST_DONE;
            ST_DONE:                         w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they can be registered.
    always_comb begin
        w_done_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_a <= A;
                    r_b <= B;
                    if (start) begin
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                ST_SUB: begin
                    // Operands drain from the bottom; differences enter at the top.
                    r_a      <= r_a >> LIMB;
                    r_b      <= r_b >> LIMB;
                    r_res    <= WIDTH'({w_d, r_res} >> LIMB);
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign C    = {r_borrow, r_res};
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: tb/tb_mp_subtractor.sv
// Self-checking bench for mp_subtractor: directed corner cases, timing,
// held-start, async reset and a randomized regression against a reference.
`timescale 1ns/1ps
module tb_mp_subtractor;

    localparam int unsigned W  = 128;
    localparam int unsigned NL = 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W:0]   C;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    mp_subtractor #(
        .WIDTH (W),
        .LIMB  (64)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .A      (A),
        .B      (B),
        .C      (C),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] diff;
        diff = a - b;
        return {(a < b), diff};
    endfunction

    function automatic logic [W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] pick(input int unsigned sel);
        logic [W-1:0] v;
        v = '0;
        case (sel)
            0: v = '0;
            1: v[63:0] = '1;
            2: v[64] = 1'b1;
            3: v = '1;
            4: v[0] = 1'b1;
            default: v = rand128();
        endcase
        return v;
    endfunction

    // Runs one operation; scrambles A/B while busy to show they are ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] c, output int lat,
                         output int bcy, output int dcy);
        bit got;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = rand128(); B = rand128();
        got = 0; lat = -1; bcy = 0; dcy = 0; c = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bcy++;
            if (done) begin
                dcy++;
                if (!got) begin
                    got = 1; lat = i; c = C;
                end
            end
            if (!busy && i > 0) break;
        end
    endtask

    initial begin
        logic [W:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat, bcy, dcy, cnt;
        bit           got, seen_idle;

        resetn = 1'b0; start = 1'b0; A = '0; B = '0;
        #12;
        check("reset_C",    C, '0);
        check("reset_done", (W+1)'(done), '0);
        check("reset_busy", (W+1)'(busy), '0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic operation with timing
        do_op(128'd5, 128'd3, c, lat, bcy, dcy);
        check("5m3_C",       c, (W+1)'(2));
        check("5m3_latency", (W+1)'(lat), (W+1)'(NL));
        check("5m3_busy",    (W+1)'(bcy), (W+1)'(3));
        check("5m3_done",    (W+1)'(dcy), (W+1)'(1));

        // Borrow propagating across the limb boundary
        a = '0; a[64] = 1'b1;
        do_op(a, 128'd1, c, lat, bcy, dcy);
        check("limb_borrow", c, {1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF});

        do_op(128'd0, 128'd1, c, lat, bcy, dcy);
        check("0m1", c, {1'b1, {W{1'b1}}});
        do_op({W{1'b1}}, {W{1'b1}}, c, lat, bcy, dcy);
        check("ones_eq", c, '0);

        // Start held high across two operations
        @(negedge clk);
        A = 128'd10; B = 128'd4; start = 1'b1;
        @(posedge clk);
        #1;
        A = 128'd99; B = 128'd1;
        got = 0; c = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1; c = C; break; end
        end
        check("hold_first_done", (W+1)'(got), (W+1)'(1));
        check("hold_first_C",    c, (W+1)'(6));
        got = 0; seen_idle = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) seen_idle = 1;
            else if (seen_idle) begin got = 1; break; end
        end
        check("hold_restart", (W+1)'(got), (W+1)'(1));
        start = 1'b0;
        got = 0; c = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1; c = C; break; end
        end
        check("hold_second_done", (W+1)'(got), (W+1)'(1));
        check("hold_second_C",    c, ref_sub(128'd99, 128'd1));
        cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("hold_no_third", (W+1)'(cnt), '0);

        // Asynchronous reset between edges during SUB
        @(negedge clk);
        A = {W{1'b1}}; B = 128'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", (W+1)'(busy), (W+1)'(1));
        #2;
        resetn = 1'b0;
        #1;
        check("async_C",    C, '0);
        check("async_done", (W+1)'(done), '0);
        check("async_busy", (W+1)'(busy), '0);
        @(negedge clk);
        resetn = 1'b1;
        do_op(128'd7, 128'd7, c, lat, bcy, dcy);
        check("post_reset_C",   c, '0);
        check("post_reset_lat", (W+1)'(lat), (W+1)'(NL));

        // Randomized regression with corner values mixed in
        for (int n = 0; n < 10000; n++) begin
            a = pick($urandom_range(0, 9));
            b = ($urandom_range(0, 7) == 0) ? a : pick($urandom_range(0, 9));
            do_op(a, b, c, lat, bcy, dcy);
            check("rand_C", c, ref_sub(a, b));
            check("rand_lat", (W+1)'(lat), (W+1)'(NL));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
